// File: rtl/nano4k_spi_flash_pkg.sv
// nano4k_spi_flash_pkg: opcodes, command classes and FSM states for the Nano4K SPI flash master
package nano4k_spi_flash_pkg;

    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_SE    = 8'h20;
    localparam logic [7:0] OP_CE    = 8'hC7;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_RDID  = 8'h9F;

    typedef enum logic [2:0] {
        CMD_ONLY,
        CMD_ADDR,
        CMD_ADDR_WR,
        CMD_ADDR_RD,
        CMD_RD
    } cmdClass_t;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT_CMD,
        SHIFT_ADDR,
        SHIFT_WR,
        SHIFT_RD,
        CS_HOLD,
        DONE_WAIT
    } state_t;

    // Unknown opcodes fall back to a bare opcode transfer.
    function automatic cmdClass_t classOf(input logic [7:0] op);
        return op == OP_SE ? CMD_ADDR :
               op == OP_PP ? CMD_ADDR_WR :
               op == OP_READ ? CMD_ADDR_RD :
               (op == OP_RDSR || op == OP_RDID) ? CMD_RD : CMD_ONLY;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: mode-0 MSB-first byte engine owning MCLK and the bit/half-period counters
module spi_byte_shifter #(
    parameter int SCLK_HALF = 1
) (
    input  logic       interfaceClk,
    input  logic       reset,
    input  logic       load,
    input  logic       preset,
    input  logic [7:0] txByte,
    input  logic       miso,
    output logic       mclk,
    output logic       mosi,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       done
);
    localparam int HW = SCLK_HALF > 1 ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

    logic          active;
    logic          phase;
    logic [HW-1:0] halfCnt;
    logic [2:0]    bitCnt;
    logic [6:0]    txShift;
    logic          halfEnd;

    assign halfEnd = active && halfCnt == HALF_LAST;
    // Combinational so the owner can reload on the final falling edge and keep bytes gapless.
    assign done = halfEnd && phase && bitCnt == 3'd7;

    always_ff @(posedge interfaceClk) begin
        if (reset) begin
            active  <= 1'b0;
            phase   <= 1'b0;
            halfCnt <= '0;
            bitCnt  <= 3'd0;
            txShift <= 7'd0;
            mclk    <= 1'b0;
            mosi    <= 1'b0;
            rxByte  <= 8'h00;
            rxValid <= 1'b0;
        end else begin
            rxValid <= 1'b0;
            if (load) begin
                active  <= 1'b1;
                phase   <= 1'b0;
                halfCnt <= '0;
                bitCnt  <= 3'd0;
                txShift <= txByte[6:0];
                mosi    <= txByte[7];
                mclk    <= 1'b0;
            end else if (preset) begin
                mosi <= txByte[7];
            end else if (active) begin
                if (halfEnd) begin
                    halfCnt <= '0;
                    phase   <= !phase;
                    mclk    <= !phase;
                    if (!phase) begin
                        rxByte  <= {rxByte[6:0], miso};
                        rxValid <= bitCnt == 3'd7;
                    end else if (bitCnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bitCnt  <= bitCnt + 3'd1;
                        mosi    <= txShift[6];
                        txShift <= {txShift[5:0], 1'b0};
                    end
                end else begin
                    halfCnt <= halfCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nano4k_spi_flash_ctrl.sv
// nano4k_spi_flash_ctrl: SPI mode-0 NOR flash master sequencing opcode, address and data phases
module nano4k_spi_flash_ctrl
    import nano4k_spi_flash_pkg::*;
#(
    parameter int SCLK_HALF   = 1,
    parameter int CS_HIGH_MIN = 4
) (
    input  logic        interfaceClk,
    input  logic        reset,
    input  logic        interfaceEnable_n,
    input  logic [7:0]  fCommand,
    input  logic [21:0] fAddress,
    input  logic [7:0]  fData_WR,
    output logic [7:0]  fData_RD,
    output logic        RdDataValid,
    output logic        WrDataReady,
    input  logic        MISO,
    output logic        MOSI,
    output logic        MCLK,
    output logic        CS_n
);
    localparam logic [15:0] SETUP_LAST = 16'(2 * SCLK_HALF - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SCLK_HALF - 1);
    localparam logic [15:0] GAP_LAST   = 16'(CS_HIGH_MIN - 1);

    state_t     state;
    cmdClass_t  cls;
    logic [7:0]  cmd;
    logic [21:0] addr;
    logic [1:0]  byteCnt;
    logic [15:0] cnt;
    logic        start;
    logic        shLoad;
    logic        shDone;
    logic        shRxValid;
    logic [7:0]  shTx;
    logic [7:0]  shRx;

    // cnt doubles as the CS-high gap timer in IDLE/DONE_WAIT and saturates there.
    assign start = state == IDLE && cnt == GAP_LAST && !interfaceEnable_n;

    always_comb begin
        shLoad = 1'b0;
        shTx   = fCommand;
        case (state)
            CS_SETUP: begin
                shLoad = cnt == SETUP_LAST;
                shTx   = cmd;
            end
            SHIFT_CMD: begin
                shLoad = shDone && cls != CMD_ONLY;
                shTx   = cls == CMD_RD ? 8'h00 : {2'b00, addr[21:16]};
            end
            SHIFT_ADDR: begin
                shLoad = shDone && (byteCnt != 2'd2 || cls == CMD_ADDR_WR || cls == CMD_ADDR_RD);
                shTx   = byteCnt == 2'd0 ? addr[15:8] :
                         byteCnt == 2'd1 ? addr[7:0] :
                         cls == CMD_ADDR_WR ? fData_WR : 8'h00;
            end
            SHIFT_WR: begin
                shLoad = shDone && !interfaceEnable_n;
                shTx   = fData_WR;
            end
            SHIFT_RD: begin
                shLoad = shDone && !interfaceEnable_n;
                shTx   = 8'h00;
            end
            default: ;
        endcase
    end

    spi_byte_shifter #(.SCLK_HALF(SCLK_HALF)) shifter (
        .interfaceClk(interfaceClk),
        .reset(reset),
        .load(shLoad),
        .preset(start),
        .txByte(shTx),
        .miso(MISO),
        .mclk(MCLK),
        .mosi(MOSI),
        .rxByte(shRx),
        .rxValid(shRxValid),
        .done(shDone)
    );

    always_ff @(posedge interfaceClk) begin
        if (reset) begin
            state       <= IDLE;
            cls         <= CMD_ONLY;
            cmd         <= 8'h00;
            addr        <= 22'd0;
            byteCnt     <= 2'd0;
            cnt         <= 16'd0;
            CS_n        <= 1'b1;
            fData_RD    <= 8'h00;
            RdDataValid <= 1'b0;
            WrDataReady <= 1'b0;
        end else begin
            RdDataValid <= shRxValid && state == SHIFT_RD;
            WrDataReady <= 1'b0;
            if (shRxValid && state == SHIFT_RD)
                fData_RD <= shRx;
            case (state)
                IDLE: begin
                    if (cnt != GAP_LAST)
                        cnt <= cnt + 16'd1;
                    if (start) begin
                        state <= CS_SETUP;
                        CS_n  <= 1'b0;
                        cmd   <= fCommand;
                        addr  <= fAddress;
                        cls   <= classOf(fCommand);
                        cnt   <= 16'd0;
                    end
                end
                CS_SETUP: begin
                    cnt <= cnt + 16'd1;
                    if (shLoad)
                        state <= SHIFT_CMD;
                end
                SHIFT_CMD: if (shDone) begin
                    byteCnt <= 2'd0;
                    cnt     <= 16'd0;
                    state   <= cls == CMD_ONLY ? CS_HOLD : (cls == CMD_RD ? SHIFT_RD : SHIFT_ADDR);
                end
                SHIFT_ADDR: if (shDone) begin
                    byteCnt <= byteCnt + 2'd1;
                    cnt     <= 16'd0;
                    if (byteCnt == 2'd2) begin
                        state       <= cls == CMD_ADDR_WR ? SHIFT_WR : (cls == CMD_ADDR_RD ? SHIFT_RD : CS_HOLD);
                        WrDataReady <= cls == CMD_ADDR_WR;
                    end
                end
                SHIFT_WR: if (shDone) begin
                    cnt <= 16'd0;
                    if (interfaceEnable_n)
                        state <= CS_HOLD;
                    else
                        WrDataReady <= 1'b1;
                end
                SHIFT_RD: if (shDone && interfaceEnable_n) begin
                    cnt   <= 16'd0;
                    state <= CS_HOLD;
                end
                CS_HOLD: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == HOLD_LAST) begin
                        CS_n        <= 1'b1;
                        cnt         <= 16'd0;
                        state       <= DONE_WAIT;
                        WrDataReady <= cls == CMD_ONLY || cls == CMD_ADDR;
                    end
                end
                DONE_WAIT: begin
                    if (cnt != GAP_LAST)
                        cnt <= cnt + 16'd1;
                    if (interfaceEnable_n)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nano4k_spi_flash_ctrl.sv
// tb_nano4k_spi_flash_ctrl: directed bench with a 256-byte mode-0 flash slave model
module tb_nano4k_spi_flash_ctrl;

    logic        interfaceClk = 1'b0;
    logic        reset = 1'b1;
    logic        interfaceEnable_n = 1'b1;
    logic [7:0]  fCommand = 8'h00;
    logic [21:0] fAddress = 22'd0;
    logic [7:0]  fData_WR = 8'h00;
    logic [7:0]  fData_RD;
    logic        RdDataValid;
    logic        WrDataReady;
    logic        MISO = 1'b0;
    logic        MOSI;
    logic        MCLK;
    logic        CS_n;

    always #5 interfaceClk = ~interfaceClk;

    nano4k_spi_flash_ctrl #(.SCLK_HALF(1), .CS_HIGH_MIN(4)) dut (
        .interfaceClk(interfaceClk),
        .reset(reset),
        .interfaceEnable_n(interfaceEnable_n),
        .fCommand(fCommand),
        .fAddress(fAddress),
        .fData_WR(fData_WR),
        .fData_RD(fData_RD),
        .RdDataValid(RdDataValid),
        .WrDataReady(WrDataReady),
        .MISO(MISO),
        .MOSI(MOSI),
        .MCLK(MCLK),
        .CS_n(CS_n)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Flash slave model state
    logic [7:0]  mem [256];
    logic [7:0]  mosiQ [$];
    logic [7:0]  opQ [$];
    logic [7:0]  pend [$];
    logic [7:0]  mSh, mOp, mOut;
    logic [23:0] mAd;
    logic        wel = 1'b0;
    logic        reading = 1'b0;
    int          bits, nb;
    int          rises = 0;
    int          badRises = 0;
    int          progCnt = 0;

    initial begin : flashModel
        logic mPrev, cPrev;
        mPrev = 1'b0;
        cPrev = 1'b1;
        foreach (mem[i]) mem[i] = 8'hFF;
        forever begin
            @(MCLK or CS_n);
            if (CS_n === 1'b1 && cPrev === 1'b0) begin
                if (bits % 8 == 0 && mOp == 8'h02 && wel && pend.size() > 0) begin
                    foreach (pend[i]) mem[mAd[7:0] + 8'(i)] = pend[i];
                    progCnt++;
                    wel = 1'b0;
                end
                reading = 1'b0;
            end else if (CS_n === 1'b0 && cPrev === 1'b1) begin
                bits = 0;
                nb = 0;
                reading = 1'b0;
                mOp = 8'h00;
                pend.delete();
            end
            if (MCLK === 1'b1 && mPrev === 1'b0) begin
                if (CS_n !== 1'b0) begin
                    badRises++;
                end else begin
                    rises++;
                    mSh = {mSh[6:0], MOSI};
                    bits++;
                    if (bits % 8 == 0) begin
                        nb++;
                        mosiQ.push_back(mSh);
                        if (nb == 1) begin
                            mOp = mSh;
                            opQ.push_back(mSh);
                            if (mSh == 8'h06) wel = 1'b1;
                            if (mSh == 8'h04) wel = 1'b0;
                            if (mSh == 8'h05) begin reading = 1'b1; mOut = 8'h03; end
                            if (mSh == 8'h9F) begin reading = 1'b1; mOut = 8'hEF; end
                        end else if (mOp == 8'h05) begin
                            mOut = 8'h03;
                        end else if (nb <= 4) begin
                            mAd = {mAd[15:0], mSh};
                            if (nb == 4 && mOp == 8'h03) begin
                                reading = 1'b1;
                                mOut = mem[mAd[7:0]];
                                mAd = mAd + 24'd1;
                            end
                        end else if (mOp == 8'h03) begin
                            mOut = mem[mAd[7:0]];
                            mAd = mAd + 24'd1;
                        end else if (mOp == 8'h02) begin
                            pend.push_back(mSh);
                        end
                    end
                end
            end else if (MCLK === 1'b0 && mPrev === 1'b1 && CS_n === 1'b0 && reading) begin
                MISO = mOut[7];
                mOut = {mOut[6:0], 1'b0};
            end
            mPrev = MCLK;
            cPrev = CS_n;
        end
    end

    // Pin-level monitor sampled mid-cycle
    logic [7:0] rdQ [$];
    int wrPulses = 0;
    int csFalls = 0;
    int gap = 0;
    int lastGap = 0;

    initial begin : monitor
        logic prevCs;
        prevCs = 1'b1;
        forever begin
            @(negedge interfaceClk);
            if (WrDataReady === 1'b1) wrPulses++;
            if (RdDataValid === 1'b1) rdQ.push_back(fData_RD);
            if (CS_n === 1'b1) gap++;
            else if (CS_n === 1'b0 && gap != 0) begin lastGap = gap; gap = 0; end
            if (CS_n === 1'b0 && prevCs === 1'b1) csFalls++;
            prevCs = CS_n;
        end
    end

    int r0, q0, w0, f0, d0, p0;

    task automatic snap();
        r0 = rises;
        q0 = mosiQ.size();
        w0 = wrPulses;
        f0 = csFalls;
        d0 = rdQ.size();
        p0 = progCnt;
    endtask

    task automatic xfer(input logic [7:0] op, input logic [21:0] ad, input int nData,
                        input logic [7:0] wd, input int hold);
        int c, wr0, rd0;
        logic isRd, isWr, released, sawLow;
        wr0 = wrPulses;
        rd0 = rdQ.size();
        isRd = op == 8'h03 || op == 8'h05 || op == 8'h9F;
        isWr = op == 8'h02;
        released = 1'b0;
        sawLow = 1'b0;
        @(negedge interfaceClk);
        fCommand = op;
        fAddress = ad;
        fData_WR = wd;
        interfaceEnable_n = 1'b0;
        for (c = 0; c < 3000; c++) begin
            @(negedge interfaceClk);
            if (CS_n === 1'b0) sawLow = 1'b1;
            if (!released && (isRd ? (CS_n === 1'b0 && rdQ.size() - rd0 >= nData - 1)
                                   : (wrPulses - wr0 >= (isWr ? nData : 1)))) begin
                repeat (hold) @(negedge interfaceClk);
                interfaceEnable_n = 1'b1;
                released = 1'b1;
            end
            if (released && sawLow && CS_n === 1'b1) break;
        end
        check($sformatf("xfer_%02h_done", op), 32'(c < 3000), 32'd1);
        repeat (4) @(negedge interfaceClk);
    endtask

    logic [7:0] ppExp [5] = '{8'h02, 8'h00, 8'h00, 8'hA0, 8'h05};

    initial begin : stimulus
        int c;
        repeat (3) @(negedge interfaceClk);
        check("rst_cs", 32'(CS_n), 32'd1);
        check("rst_mclk", 32'(MCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_rd", 32'(fData_RD), 32'h00);
        check("rst_rdv", 32'(RdDataValid), 32'd0);
        check("rst_wrr", 32'(WrDataReady), 32'd0);
        reset = 1'b0;

        // RSTEN, enable held low well past completion: no retrigger
        snap();
        xfer(8'h66, 22'd0, 0, 8'h00, 30);
        check("rsten_rises", 32'(rises - r0), 32'd8);
        check("rsten_byte", 32'(mosiQ[q0]), 32'h66);
        check("rsten_wrr", 32'(wrPulses - w0), 32'd1);
        check("rsten_nofire", 32'(csFalls - f0), 32'd1);
        check("rsten_cs", 32'(CS_n), 32'd1);

        snap();
        xfer(8'h06, 22'd0, 0, 8'h00, 0);
        check("wren_rises", 32'(rises - r0), 32'd8);
        check("wren_byte", 32'(mosiQ[q0]), 32'h06);

        snap();
        xfer(8'h02, 22'h0000A0, 1, 8'h05, 0);
        check("pp_rises", 32'(rises - r0), 32'd40);
        for (int i = 0; i < 5; i++)
            check($sformatf("pp_byte%0d", i), 32'(mosiQ[q0 + i]), 32'(ppExp[i]));
        check("pp_wrr", 32'(wrPulses - w0), 32'd1);
        check("pp_mem", 32'(mem[8'hA0]), 32'h05);

        xfer(8'h06, 22'd0, 0, 8'h00, 0);
        xfer(8'h02, 22'h0000A1, 1, 8'hA7, 0);
        check("pp2_mem", 32'(mem[8'hA1]), 32'hA7);

        snap();
        xfer(8'h03, 22'h0000A0, 2, 8'h00, 0);
        check("read_rises", 32'(rises - r0), 32'd48);
        check("read_cnt", 32'(rdQ.size() - d0), 32'd2);
        check("read_b0", 32'(rdQ[d0]), 32'h05);
        check("read_b1", 32'(rdQ[d0 + 1]), 32'hA7);

        snap();
        xfer(8'h05, 22'd0, 1, 8'h00, 0);
        check("rdsr_rises", 32'(rises - r0), 32'd16);
        check("rdsr_cnt", 32'(rdQ.size() - d0), 32'd1);
        check("rdsr_val", 32'(fData_RD), 32'h03);

        // Reset lands right after the 12th MCLK rise of a program
        xfer(8'h06, 22'd0, 0, 8'h00, 0);
        snap();
        @(negedge interfaceClk);
        fCommand = 8'h02;
        fAddress = 22'h0000A2;
        fData_WR = 8'h5A;
        interfaceEnable_n = 1'b0;
        for (c = 0; c < 500 && rises - r0 < 12; c++) @(negedge interfaceClk);
        check("abort_reach", 32'(rises - r0), 32'd12);
        reset = 1'b1;
        @(negedge interfaceClk);
        check("abort_cs", 32'(CS_n), 32'd1);
        check("abort_mclk", 32'(MCLK), 32'd0);
        check("abort_mosi", 32'(MOSI), 32'd0);
        check("abort_wrr", 32'(WrDataReady), 32'd0);
        check("abort_rdv", 32'(RdDataValid), 32'd0);
        check("abort_rd", 32'(fData_RD), 32'h00);
        reset = 1'b0;
        interfaceEnable_n = 1'b1;
        repeat (10) @(negedge interfaceClk);
        check("abort_rises", 32'(rises - r0), 32'd12);
        check("abort_noprog", 32'(progCnt - p0), 32'd0);
        check("abort_mem", 32'(mem[8'hA2]), 32'hFF);

        // Back-to-back commands must respect the CS-high gap
        snap();
        xfer(8'h66, 22'd0, 0, 8'h00, 0);
        xfer(8'h99, 22'd0, 0, 8'h00, 0);
        check("b2b_gap", 32'(lastGap >= 4), 32'd1);
        check("b2b_op0", 32'(opQ[opQ.size() - 2]), 32'h66);
        check("b2b_op1", 32'(opQ[opQ.size() - 1]), 32'h99);
        check("b2b_rises", 32'(rises - r0), 32'd16);
        check("bad_rises", 32'(badRises), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nano4k_spi_flash_ctrl.md
Name: nano4k_spi_flash_ctrl

Overview:
Single-clock SPI NOR flash master for the Nano4K on-package flash, in SPI mode 0 with MSB-first bit order. A host issues a command by driving an opcode, a 22-bit address and write data, then pulling interfaceEnable_n low. The controller serialises the opcode, address and data onto MOSI/MCLK/CS_n and streams read data back with per-byte strobes. It sits between user logic (test sequencer, CPU bridge) and the flash pins.

Parameters:
SCLK_HALF, 1, interfaceClk cycles per MCLK half-period (MCLK = interfaceClk/(2*SCLK_HALF)); must be ≥1.
CS_HIGH_MIN, 4, minimum interfaceClk cycles CS_n stays high between transactions.

Ports:
interfaceClk  in  1  sole clock; all logic on its rising edge
reset  in  1  synchronous, active-high
interfaceEnable_n  in  1  active-low request/continue level
fCommand  in  8  opcode, latched at transaction start
fAddress  in  22  byte address, latched at start; sent as 24 bits {2'b00, fAddress}
fData_WR  in  8  program data, latched at each data-byte load
fData_RD  out  8  last received byte
RdDataValid  out  1  one-cycle strobe: fData_RD holds a new byte
WrDataReady  out  1  one-cycle strobe: write byte consumed, or single-byte/no-data command finished
MISO  in  1  flash serial out
MOSI  out  1  flash serial in
MCLK  out  1  serial clock, idles low
CS_n  out  1  chip select, active low

Behaviour:
- Reset values: CS_n=1, MCLK=0, MOSI=0, fData_RD=0x00, RdDataValid=0, WrDataReady=0, FSM=IDLE, counters=0.
- Reset asserted mid-transfer aborts on the next edge; the reset values above apply.
- Command classes, defined in the package:
  - CMD_ONLY: RSTEN 0x66, RST 0x99, WREN 0x06, WRDI 0x04, CE 0xC7.
  - CMD_ADDR: SE 0x20.
  - CMD_ADDR_WR: PP 0x02.
  - CMD_ADDR_RD: READ 0x03.
  - CMD_RD: RDSR 0x05, RDID 0x9F.
  - Any other opcode is handled as CMD_ONLY.
- FSM states: IDLE → CS_SETUP → SHIFT_CMD → [SHIFT_ADDR] → [SHIFT_WR | SHIFT_RD] → CS_HOLD → DONE_WAIT → IDLE.
- IDLE: the FSM samples interfaceEnable_n=0 only after the CS_HIGH_MIN counter has expired. On that sample it latches fCommand/fAddress; CS_n falls on the next cycle.
- CS_SETUP: CS_n low for one full MCLK period with MCLK low. MOSI presents opcode bit7.
- Bit timing (mode 0):
  - MOSI changes while MCLK is low.
  - MCLK rises SCLK_HALF cycles later; MISO is sampled on that rising edge.
  - MCLK falls SCLK_HALF cycles after the rise.
  - One byte takes 16*SCLK_HALF cycles. MCLK produces exactly 8 rises per byte.
- SHIFT_ADDR: 3 bytes, MSB first.
- SHIFT_WR:
  - fData_WR is latched at the first bit of each data byte, and WrDataReady pulses in that cycle. The host then has one byte-time to present the next byte.
  - At each byte boundary: if interfaceEnable_n=0, shift another byte; otherwise go to CS_HOLD.
- SHIFT_RD:
  - After the 8th rising edge of a byte, fData_RD updates and RdDataValid pulses for one cycle.
  - At the byte boundary: if interfaceEnable_n=1, go to CS_HOLD; otherwise continue reading. The flash auto-increments the address.
- CS_HOLD: MCLK low for SCLK_HALF cycles, then CS_n rises. For CMD_ONLY and CMD_ADDR, WrDataReady pulses on the cycle CS_n rises.
- DONE_WAIT: holds until interfaceEnable_n=1, then goes to IDLE. An enable held low never retriggers a command; each command needs a high→low transition of interfaceEnable_n.
- Enable deasserted mid-opcode or mid-address: the opcode/address phase still completes. The data phase transfers one byte for PP, and a read delivers one byte.
- Outputs are registered; MOSI/MCLK/CS_n are glitch-free.

Decomposition:
- Package nano4k_spi_flash_pkg: opcode constants (RSTEN, RST, WREN, WRDI, PP, READ, SE, CE, RDSR, RDID), the command-class enum, the opcode→class function, and the FSM state typedef.
- Sub-module spi_byte_shifter: a mode-0 8-bit shift engine.
  - Inputs: load, tx byte.
  - Outputs: rx byte, done.
  - Owns MCLK generation and bit/half-period counters.
- Top holds the FSM, latches and strobes.

Test Plan:
- Flash model: an SPI mode-0 slave with 256 B of memory; SCLK_HALF=1.
- RSTEN: fCommand=0x66, enable low, released on WrDataReady → MOSI 0x66 over exactly 8 MCLK rises; CS_n low for the whole byte; one WrDataReady pulse; CS_n high; no second transaction while enable is still low.
- WREN then PP: fCommand=0x02, fAddress=0x00A0, fData_WR=0x05, enable held low for 1 data byte → MOSI 02 00 00 A0 05 (40 rises); WrDataReady pulses once at the data-byte load; CS_n rises after byte 5; model byte 0xA0=0x05.
- READ: fCommand=0x03, fAddress=0x00A0, enable low for 2 bytes, model holds 05 A7 → RdDataValid pulses twice with fData_RD=0x05 then 0xA7; exactly 48 rises.
- RDSR: model status 0x03 → fData_RD=0x03 after 16 rises.
- Reset asserted at rise #12 of PP → next cycle CS_n=1, MCLK=0, MOSI=0, strobes 0; the model sees no program.
- Back-to-back: RSTEN then RST issued immediately → CS_n high for ≥4 cycles between them; model reports both opcodes received.
